// File: rtl/data_ram_if.sv
// data_ram_if: request/response bus between a load/store master and data_ram
// master: drives req_valid/req_we/req_funct3/req_addr/req_wdata and resp_ready
// slave : drives req_ready and resp_valid/resp_rdata/resp_fault
interface data_ram_if;
  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic [2:0]  req_funct3;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        resp_valid;
  logic        resp_ready;
  logic [31:0] resp_rdata;
  logic        resp_fault;
  modport master(output req_valid, req_we, req_funct3, req_addr, req_wdata, resp_ready,
                 input req_ready, resp_valid, resp_rdata, resp_fault);
  modport slave(input req_valid, req_we, req_funct3, req_addr, req_wdata, resp_ready,
                output req_ready, resp_valid, resp_rdata, resp_fault);
endinterface

// File: rtl/data_ram.sv
// data_ram: 32-bit word RAM with RV32I byte/half/word load-store and one-cycle valid/ready response
// Ports: clk, rst_n (async active-low), bus (data_ram_if.slave request/response channel)
// Params: ADDR_W word-address bits (depth 2**ADDR_W), INIT_ZERO clears contents at time zero in simulation
// Macro DATA_RAM_MISALIGN_TRAP_EN: misaligned H/HU/W fault instead of being forced to natural alignment
module data_ram #(
  parameter int ADDR_W = 8,
  parameter int INIT_ZERO = 0
) (
  input logic       clk,
  input logic       rst_n,
  data_ram_if.slave bus
);
  typedef enum logic {IDLE, RESP} state_t;
  localparam int DEPTH = 2**ADDR_W;
  state_t state, state_nx;
  logic [31:0] mem [DEPTH] = '{default: (INIT_ZERO != 0) ? 32'h0 : 32'hx};
  logic [2:0] f3, r_f3;
  logic [1:0] off, r_off;
  logic [3:0] be;
  logic [ADDR_W-1:0] idx;
  logic [31:0] wd, r_word, ext;
  logic [15:0] h;
  logic [7:0] b;
  logic accept, illegal, misalign, fault, wr, r_we, r_fault, unused_addr;
  assign f3 = bus.req_funct3;
  assign idx = bus.req_addr[ADDR_W+1:2];
  assign unused_addr = ^bus.req_addr[31:ADDR_W+2];
  // gating with rst_n keeps reset cycles from accepting or writing
  assign accept = rst_n && bus.req_valid && bus.req_ready;
  assign illegal = f3 == 3'b011 || f3[2:1] == 2'b11 || (bus.req_we && f3[2]);
`ifdef DATA_RAM_MISALIGN_TRAP_EN
  assign misalign = (f3[1:0] == 2'b01 && bus.req_addr[0]) || (f3[1:0] == 2'b10 && bus.req_addr[1:0] != 2'b00);
`else
  assign misalign = 1'b0;
`endif
  assign fault = illegal || misalign;
  // byte offset after forcing halves and words to natural alignment
  assign off = f3[1:0] == 2'b10 ? 2'b00 : f3[1:0] == 2'b01 ? {bus.req_addr[1], 1'b0} : bus.req_addr[1:0];
  assign be = f3[1:0] == 2'b10 ? 4'hf : f3[1:0] == 2'b01 ? 4'h3 << off : 4'h1 << off;
  // replicate right-aligned store data so every enabled lane sees its bytes
  assign wd = f3[1:0] == 2'b10 ? bus.req_wdata : f3[1:0] == 2'b01 ? {2{bus.req_wdata[15:0]}} : {4{bus.req_wdata[7:0]}};
  assign wr = accept && bus.req_we && !fault;
  always_ff @(posedge clk) begin
    if (accept) r_word <= mem[idx];
    if (wr)
      for (int i = 0; i < 4; i++)
        if (be[i]) mem[idx][8*i +: 8] <= wd[8*i +: 8];
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      r_we <= 1'b0;
      r_f3 <= 3'b000;
      r_off <= 2'b00;
      r_fault <= 1'b0;
    end else if (accept) begin
      r_we <= bus.req_we;
      r_f3 <= f3;
      r_off <= off;
      r_fault <= fault;
    end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) state <= IDLE;
    else state <= state_nx;
  always_comb state_nx = accept ? RESP : (state == RESP && bus.resp_ready) ? IDLE : state;
  assign b = r_word[8*r_off +: 8];
  assign h = r_word[16*r_off[1] +: 16];
  assign ext = r_f3[1:0] == 2'b10 ? r_word :
               r_f3[1:0] == 2'b01 ? {{16{!r_f3[2] && h[15]}}, h} : {{24{!r_f3[2] && b[7]}}, b};
  always_comb begin
    bus.req_ready = state == IDLE || bus.resp_ready;
    bus.resp_valid = state == RESP;
    bus.resp_fault = state == RESP && r_fault;
    bus.resp_rdata = (state == RESP && !r_we && !r_fault) ? ext : 32'h0;
  end
endmodule

// File: doc/data_ram.md
DATA_RAM -- requirements
Module: data_ram

Interface
REQ-001 SHALL have parameter ADDR_W, default 8, meaning word-address bits; depth is 2**ADDR_W 32-bit words.
REQ-002 SHALL have parameter INIT_ZERO, default 0, meaning 1 clears all words at time zero for simulation; 0 leaves contents undefined.
REQ-003 SHALL have port clk  input  1  single clock; all state changes on its rising edge.
REQ-004 SHALL have port rst_n  input  1  reset, asynchronous and active-low.
REQ-005 SHALL have port req_valid  input  1  request present.
REQ-006 SHALL have port req_ready  output  1  request accepted when high with req_valid.
REQ-007 SHALL have port req_we  input  1  1 store, 0 load.
REQ-008 SHALL have port req_funct3  input  3  access type in RV32I encoding: 000 B, 001 H, 010 W, 100 BU, 101 HU.
REQ-009 SHALL have port req_addr  input  32  byte address.
REQ-010 SHALL have port req_wdata  input  32  store data, right-aligned.
REQ-011 SHALL have port resp_valid  output  1  response present.
REQ-012 SHALL have port resp_ready  input  1  response consumed when high with resp_valid.
REQ-013 SHALL have port resp_rdata  output  32  extended load data; 0 for stores and faults.
REQ-014 SHALL have port resp_fault  output  1  access rejected.

Function
REQ-015 SHALL implement a two-state FSM: IDLE and RESP.
REQ-016 req_ready SHALL be high in IDLE, and in RESP only while resp_ready is high (back-to-back, one access per cycle).
REQ-017 On accept, the FSM SHALL enter RESP; in RESP with resp_ready high and no new accept, it SHALL return to IDLE.
REQ-018 Latency SHALL be one cycle: resp_valid rises on the edge after acceptance for both loads and stores.
REQ-019 resp_valid, resp_rdata and resp_fault SHALL stay stable while resp_valid is high and resp_ready is low.
REQ-020 Word index SHALL be req_addr[ADDR_W+1:2]; higher address bits are ignored, so addresses wrap modulo 4*2**ADDR_W bytes.
REQ-021 Stores SHALL write only the addressed byte lanes at the accept edge: B writes lane addr[1:0], H writes lanes addr[1]*2 and addr[1]*2+1, W writes all four; other lanes are unchanged.
REQ-022 Loads SHALL read the word at the accept edge; lane selection and extension SHALL use offset and funct3 registered at accept.
REQ-023 Extension: B and H SHALL sign-extend; BU and HU SHALL zero-extend; W SHALL return the word unmodified.
REQ-024 A load accepted on the cycle after a store to the same word SHALL return the post-store data.
REQ-025 req_funct3 values 011, 110 and 111 SHALL set resp_fault=1 and perform no write.
REQ-026 A store with funct3 100 or 101 SHALL be treated as illegal per REQ-025.
REQ-027 Requests SHALL NOT be accepted while req_valid is low; req_* inputs are don't-care then.

Reset
REQ-028 rst_n low SHALL immediately force IDLE, resp_valid=0, resp_rdata=0 and resp_fault=0; req_ready SHALL read 1 once rst_n is high.
REQ-029 A pending response SHALL be discarded by reset.
REQ-030 No write SHALL occur on any edge where rst_n is low.
REQ-031 Memory contents SHALL NOT be altered by reset.

Configuration
REQ-032 Macro DATA_RAM_MISALIGN_TRAP_EN defined: H/HU with addr[0]=1 and W with addr[1:0]!=0 SHALL set resp_fault=1, resp_rdata=0, and perform no write.
REQ-033 Macro DATA_RAM_MISALIGN_TRAP_EN undefined: misaligned accesses SHALL be forced to natural alignment (H ignores addr[0], W ignores addr[1:0]), and misalignment SHALL never set resp_fault.

Verification
REQ-034 Reset: assert rst_n=0 while in RESP -> resp_valid=0 asynchronously; after release, req_ready=1.
REQ-035 Sequence: SW 0x11223344 @0x10, SB 0xAA @0x12, LW @0x10 -> 0x11AA3344; LB @0x12 -> 0xFFFFFFAA; LBU @0x12 -> 0x000000AA.
REQ-036 Sequence: SH 0x8001 @0x22, LH @0x22 -> 0xFFFF8001; LHU @0x22 -> 0x00008001; LW @0x20 -> upper half 0x8001, lower half unchanged.
REQ-037 Back-pressure: hold resp_ready=0 for 3 cycles -> resp_* stable and req_ready=0; then hold resp_ready=1 with continuous req_valid -> one response per cycle.
REQ-038 Wrap: ADDR_W=8, SW 0xDEADBEEF @0x400, LW @0x000 -> 0xDEADBEEF.
REQ-039 Faults: funct3=011 -> resp_fault=1; LW @0x13 with macro defined -> fault=1 and no write; without macro -> data from word 0x10, fault=0.
